// File: rtl/snoop_dispatch_if.sv
// Packet stream carried into snoop_dispatch: data beats with valid/ready, last flag and
// a byte count that applies to the final beat.
interface snoop_dispatch_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned INC_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0] s_tdata;
    logic                  s_tvalid;
    logic                  s_tlast;
    logic [INC_WIDTH-1:0]  s_tbytes;
    logic                  s_tready;

    modport master (output s_tdata, s_tvalid, s_tlast, s_tbytes, input s_tready);
    modport slave  (input s_tdata, s_tvalid, s_tlast, s_tbytes, output s_tready);
endinterface

// File: rtl/snoop_dispatch.sv
// Dispatches an incoming packet stream to one of N packetfilter cores, claiming a free core
// round-robin and writing the packet through that core's snooper port.
module snoop_dispatch #(
    parameter int unsigned N_CORES            = 4,
    parameter int unsigned PACKMEM_DATA_WIDTH = 64,
    parameter int unsigned PACKET_MEM_BYTES   = 2048,
    parameter int unsigned DROP_WHEN_BUSY     = 0,
    localparam int unsigned BYTES_PER_WORD = PACKMEM_DATA_WIDTH / 8,
    localparam int unsigned ADDR_WIDTH     = $clog2(PACKET_MEM_BYTES) - $clog2(BYTES_PER_WORD),
    localparam int unsigned INC_WIDTH      = $clog2(BYTES_PER_WORD) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    snoop_dispatch_if.slave               s,
    output logic [ADDR_WIDTH-1:0]         sn_addr,
    output logic [PACKMEM_DATA_WIDTH-1:0] sn_wr_data,
    output logic [INC_WIDTH-1:0]          sn_byte_inc,
    output logic [N_CORES-1:0]            sn_wr_en,
    output logic [N_CORES-1:0]            sn_done,
    input  logic [N_CORES-1:0]            rdy_for_sn,
    output logic [N_CORES-1:0]            rdy_for_sn_ack,
    output logic [31:0]                   drop_cnt,
    output logic [31:0]                   trunc_cnt
);
    localparam int unsigned SEL_WIDTH = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int unsigned MAX_BEATS = PACKET_MEM_BYTES / BYTES_PER_WORD;
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CntMax  = CNT_WIDTH'(MAX_BEATS);
    localparam logic [INC_WIDTH-1:0] FullInc = INC_WIDTH'(BYTES_PER_WORD);
    localparam logic [SEL_WIDTH-1:0] LastSel = SEL_WIDTH'(N_CORES - 1);

    typedef enum logic [2:0] {StIdle, StClaim, StStream, StDone, StDrop} state_e;

    state_e                  state_q, state_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [SEL_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
    logic                    trunc_seen_q, trunc_seen_d;
    logic [SEL_WIDTH-1:0]    pick;
    logic                    found;
    int unsigned             scan_idx;
    logic                    tready;
    logic [N_CORES-1:0]      sel_onehot, pick_onehot;

    logic [ADDR_WIDTH-1:0]         sn_addr_d;
    logic [PACKMEM_DATA_WIDTH-1:0] sn_wr_data_d;
    logic [INC_WIDTH-1:0]          sn_byte_inc_d;
    logic [N_CORES-1:0]            sn_wr_en_d, sn_done_d, ack_d;
    logic [31:0]                   drop_cnt_d, trunc_cnt_d;

    // First ready core at or after rr_ptr, wrapping modulo N_CORES.
    always_comb begin
        found    = 1'b0;
        pick     = rr_ptr_q;
        scan_idx = 0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            scan_idx = 32'(rr_ptr_q) + i;
            if (scan_idx >= N_CORES) begin
                scan_idx = scan_idx - N_CORES;
            end
            if (!found && rdy_for_sn[scan_idx[SEL_WIDTH-1:0]]) begin
                found = 1'b1;
                pick  = scan_idx[SEL_WIDTH-1:0];
            end
        end
    end

    assign sel_onehot  = N_CORES'(1) << sel_q;
    assign pick_onehot = N_CORES'(1) << pick;
    assign s.s_tready  = tready;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        rr_ptr_d      = rr_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        trunc_seen_d  = trunc_seen_q;
        tready        = 1'b0;
        sn_addr_d     = sn_addr;
        sn_wr_data_d  = sn_wr_data;
        sn_byte_inc_d = sn_byte_inc;
        sn_wr_en_d    = '0;
        sn_done_d     = '0;
        ack_d         = '0;
        drop_cnt_d    = drop_cnt;
        trunc_cnt_d   = trunc_cnt;

        unique case (state_q)
            StIdle: begin
                if (s.s_tvalid && found) begin
                    sel_d   = pick;
                    ack_d   = pick_onehot;
                    state_d = StClaim;
                end else if (s.s_tvalid && (DROP_WHEN_BUSY != 0)) begin
                    state_d = StDrop;
                end
            end
            StClaim: begin
                beat_cnt_d   = '0;
                trunc_seen_d = 1'b0;
                rr_ptr_d     = (sel_q == LastSel) ? '0 : sel_q + 1'b1;
                state_d      = StStream;
            end
            StStream: begin
                tready = 1'b1;
                if (s.s_tvalid) begin
                    // Counter parks at CntMax so overflow beats are accepted but never written.
                    if (beat_cnt_q != CntMax) begin
                        sn_wr_en_d    = sel_onehot;
                        sn_addr_d     = beat_cnt_q[ADDR_WIDTH-1:0];
                        sn_wr_data_d  = s.s_tdata;
                        sn_byte_inc_d = s.s_tlast ? s.s_tbytes : FullInc;
                        beat_cnt_d    = beat_cnt_q + 1'b1;
                    end else if (!trunc_seen_q) begin
                        trunc_seen_d = 1'b1;
                        if (trunc_cnt != '1) begin
                            trunc_cnt_d = trunc_cnt + 32'd1;
                        end
                    end
                    if (s.s_tlast) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                sn_done_d = sel_onehot;
                state_d   = StIdle;
            end
            StDrop: begin
                tready = 1'b1;
                if (s.s_tvalid && s.s_tlast) begin
                    if (drop_cnt != '1) begin
                        drop_cnt_d = drop_cnt + 32'd1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            sel_q          <= '0;
            rr_ptr_q       <= '0;
            beat_cnt_q     <= '0;
            trunc_seen_q   <= 1'b0;
            sn_addr        <= '0;
            sn_wr_data     <= '0;
            sn_byte_inc    <= '0;
            sn_wr_en       <= '0;
            sn_done        <= '0;
            rdy_for_sn_ack <= '0;
            drop_cnt       <= '0;
            trunc_cnt      <= '0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            rr_ptr_q       <= rr_ptr_d;
            beat_cnt_q     <= beat_cnt_d;
            trunc_seen_q   <= trunc_seen_d;
            sn_addr        <= sn_addr_d;
            sn_wr_data     <= sn_wr_data_d;
            sn_byte_inc    <= sn_byte_inc_d;
            sn_wr_en       <= sn_wr_en_d;
            sn_done        <= sn_done_d;
            rdy_for_sn_ack <= ack_d;
            drop_cnt       <= drop_cnt_d;
            trunc_cnt      <= trunc_cnt_d;
        end
    end
endmodule

// File: tb/tb_snoop_dispatch.sv
// Directed bench for snoop_dispatch: a backpressure instance and a drop-when-busy instance
// share one stream driver; a negedge monitor logs snooper activity for the tests to inspect.
module tb_snoop_dispatch;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [63:0] tdata  = '0;
    logic        tvalid = 1'b0;
    logic        tlast  = 1'b0;
    logic [3:0]  tbytes = 4'd8;
    logic        use_d  = 1'b0;
    logic [3:0]  rdy_a  = 4'hF;
    logic [3:0]  rdy_d  = 4'h0;
    logic [31:0] pkt_id = 32'h100;

    snoop_dispatch_if #(.DATA_WIDTH(64), .INC_WIDTH(4)) if_a ();
    snoop_dispatch_if #(.DATA_WIDTH(64), .INC_WIDTH(4)) if_d ();

    assign if_a.s_tdata  = tdata;
    assign if_a.s_tvalid = tvalid & ~use_d;
    assign if_a.s_tlast  = tlast;
    assign if_a.s_tbytes = tbytes;
    assign if_d.s_tdata  = tdata;
    assign if_d.s_tvalid = tvalid & use_d;
    assign if_d.s_tlast  = tlast;
    assign if_d.s_tbytes = tbytes;

    wire tready_sel = use_d ? if_d.s_tready : if_a.s_tready;

    logic [7:0]  a_addr, d_addr;
    logic [63:0] a_data, d_data;
    logic [3:0]  a_inc, d_inc, a_wr_en, d_wr_en, a_done, d_done, a_ack, d_ack;
    logic [31:0] a_drop, d_drop, a_trunc, d_trunc;

    snoop_dispatch #(.N_CORES(4), .PACKMEM_DATA_WIDTH(64), .PACKET_MEM_BYTES(2048),
                     .DROP_WHEN_BUSY(0)) dut (
        .clk(clk), .rst(rst), .s(if_a.slave), .sn_addr(a_addr), .sn_wr_data(a_data),
        .sn_byte_inc(a_inc), .sn_wr_en(a_wr_en), .sn_done(a_done), .rdy_for_sn(rdy_a),
        .rdy_for_sn_ack(a_ack), .drop_cnt(a_drop), .trunc_cnt(a_trunc)
    );

    snoop_dispatch #(.N_CORES(4), .PACKMEM_DATA_WIDTH(64), .PACKET_MEM_BYTES(2048),
                     .DROP_WHEN_BUSY(1)) dut_d (
        .clk(clk), .rst(rst), .s(if_d.slave), .sn_addr(d_addr), .sn_wr_data(d_data),
        .sn_byte_inc(d_inc), .sn_wr_en(d_wr_en), .sn_done(d_done), .rdy_for_sn(rdy_d),
        .rdy_for_sn_ack(d_ack), .drop_cnt(d_drop), .trunc_cnt(d_trunc)
    );

    int total = 0;
    int bad   = 0;
    int onehot_bad = 0;
    int d_act = 0;
    int          wr_core[$];
    int          wr_addr[$];
    int          wr_inc[$];
    logic [63:0] wr_data[$];
    int          done_log[$];
    int          ack_log[$];

    always @(negedge clk) begin
        if ($countones(a_wr_en) > 1 || $countones(a_done) > 1 || $countones(a_ack) > 1)
            onehot_bad++;
        for (int i = 0; i < N; i++) begin
            if (a_wr_en[i]) begin
                wr_core.push_back(i);
                wr_addr.push_back(int'(a_addr));
                wr_inc.push_back(int'(a_inc));
                wr_data.push_back(a_data);
            end
            if (a_done[i]) done_log.push_back(i);
            if (a_ack[i]) ack_log.push_back(i);
        end
        if ((|d_wr_en) || (|d_done) || (|d_ack)) d_act++;
    end

    task automatic clear_logs();
        wr_core.delete(); wr_addr.delete(); wr_inc.delete(); wr_data.delete();
        done_log.delete(); ack_log.delete();
    endtask

    task automatic do_reset();
        tvalid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_logs();
    endtask

    // Drives one packet starting at a negedge; returns at the negedge after the last
    // accepted beat, or after stop_after accepted beats when stop_after > 0.
    task automatic send_pkt(input int nbeats, input int lastb, input bit toggle,
                            input int stop_after, output int acc);
        int waitc;
        acc = 0;
        for (int b = 0; b < nbeats; b++) begin
            if (toggle && (b % 2 == 1)) begin
                tvalid = 1'b0;
                @(negedge clk);
            end
            tdata  = {pkt_id, 32'(b)};
            tlast  = (b == nbeats - 1);
            tbytes = tlast ? 4'(lastb) : 4'd8;
            tvalid = 1'b1;
            waitc  = 0;
            while (!tready_sel) begin
                @(negedge clk);
                waitc++;
                if (waitc > 2000) begin
                    total++; bad++;
                    $display("FAIL handshake_timeout beat=%0d got=tready_low want=tready_high", b);
                    tvalid = 1'b0;
                    return;
                end
            end
            @(negedge clk);
            acc++;
            if (stop_after > 0 && acc == stop_after) begin
                tvalid = 1'b0;
                return;
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        pkt_id = pkt_id + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        total++;
        if ({a_wr_en, a_done, a_ack, if_a.s_tready} !== 13'd0 || a_addr !== 8'd0 ||
            a_data !== 64'd0 || a_inc !== 4'd0) begin
            bad++;
            $display("FAIL reset_outputs got wr=%h done=%h ack=%h rdy=%b addr=%h inc=%h want=0",
                     a_wr_en, a_done, a_ack, if_a.s_tready, a_addr, a_inc);
        end
        total++;
        if (a_drop !== 32'd0 || a_trunc !== 32'd0 || d_drop !== 32'd0 || d_trunc !== 32'd0) begin
            bad++;
            $display("FAIL reset_counters got %0d %0d %0d %0d want 0 0 0 0",
                     a_drop, a_trunc, d_drop, d_trunc);
        end
        do_reset();
    endtask

    task automatic test_round_robin();
        int acc;
        int exp_addr[6] = '{0, 1, 0, 1, 0, 1};
        int exp_core[6] = '{0, 0, 1, 1, 2, 2};
        int exp_inc[6]  = '{8, 5, 8, 5, 8, 5};
        logic [31:0] base;
        do_reset();
        rdy_a = 4'hF;
        base  = pkt_id;
        for (int p = 0; p < 3; p++) send_pkt(2, 5, 1'b0, 0, acc);
        repeat (4) @(negedge clk);
        total++;
        if (ack_log.size() != 3 || ack_log[0] != 0 || ack_log[1] != 1 || ack_log[2] != 2) begin
            bad++;
            $display("FAIL rr_acks got n=%0d %p want 0,1,2", ack_log.size(), ack_log);
        end
        total++;
        if (wr_core.size() != 6) begin
            bad++;
            $display("FAIL rr_write_count got %0d want 6", wr_core.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                total++;
                if (wr_core[k] != exp_core[k] || wr_addr[k] != exp_addr[k] ||
                    wr_inc[k] != exp_inc[k]) begin
                    bad++;
                    $display("FAIL rr_write%0d got core=%0d addr=%0d inc=%0d want %0d %0d %0d",
                             k, wr_core[k], wr_addr[k], wr_inc[k],
                             exp_core[k], exp_addr[k], exp_inc[k]);
                end
            end
            total++;
            if (wr_data[3] !== {base + 32'd1, 32'd1}) begin
                bad++;
                $display("FAIL rr_data got %h want %h", wr_data[3], {base + 32'd1, 32'd1});
            end
        end
        total++;
        if (done_log.size() != 3 || done_log[0] != 0 || done_log[1] != 1 || done_log[2] != 2) begin
            bad++;
            $display("FAIL rr_done got %p want 0,1,2", done_log);
        end
    endtask

    task automatic test_rr_sparse();
        int acc;
        do_reset();
        rdy_a = 4'b1010;
        for (int p = 0; p < 3; p++) send_pkt(1, 8, 1'b0, 0, acc);
        repeat (4) @(negedge clk);
        total++;
        if (ack_log.size() != 3 || ack_log[0] != 1 || ack_log[1] != 3 || ack_log[2] != 1) begin
            bad++;
            $display("FAIL sparse_acks got %p want 1,3,1", ack_log);
        end
        total++;
        if (done_log.size() != 3 || done_log[0] != 1 || done_log[1] != 3 || done_log[2] != 1) begin
            bad++;
            $display("FAIL sparse_done got %p want 1,3,1", done_log);
        end
        rdy_a = 4'hF;
    endtask

    task automatic test_truncation();
        int acc;
        int order_err;
        do_reset();
        send_pkt(260, 8, 1'b0, 0, acc);
        repeat (4) @(negedge clk);
        total++;
        if (acc != 260) begin
            bad++;
            $display("FAIL trunc_accepted got %0d want 260", acc);
        end
        total++;
        if (wr_addr.size() != 256) begin
            bad++;
            $display("FAIL trunc_writes got %0d want 256", wr_addr.size());
        end
        order_err = 0;
        foreach (wr_addr[k]) if (wr_addr[k] != k || wr_core[k] != 0) order_err++;
        total++;
        if (order_err != 0) begin
            bad++;
            $display("FAIL trunc_addr_order got %0d bad entries want 0", order_err);
        end
        total++;
        if (a_trunc !== 32'd1) begin
            bad++;
            $display("FAIL trunc_cnt got %0d want 1", a_trunc);
        end
        total++;
        if (done_log.size() != 1 || done_log[0] != 0) begin
            bad++;
            $display("FAIL trunc_done got %p want single pulse on core 0", done_log);
        end
    endtask

    task automatic test_drop();
        int acc;
        int hi;
        do_reset();
        use_d = 1'b1;
        rdy_d = 4'h0;
        d_act = 0;
        send_pkt(3, 4, 1'b0, 0, acc);
        repeat (3) @(negedge clk);
        total++;
        if (acc != 3 || d_drop !== 32'd1) begin
            bad++;
            $display("FAIL drop_three_beat got acc=%0d drop=%0d want 3 1", acc, d_drop);
        end
        send_pkt(1, 2, 1'b0, 0, acc);
        repeat (3) @(negedge clk);
        total++;
        if (d_drop !== 32'd2) begin
            bad++;
            $display("FAIL drop_single_beat got %0d want 2", d_drop);
        end
        total++;
        if (d_act != 0 || d_trunc !== 32'd0) begin
            bad++;
            $display("FAIL drop_no_activity got act=%0d trunc=%0d want 0 0", d_act, d_trunc);
        end
        // Backpressure instance: no ready core, so the stream must stall.
        use_d = 1'b0;
        rdy_a = 4'h0;
        clear_logs();
        tdata  = {pkt_id, 32'd0};
        tlast  = 1'b0;
        tvalid = 1'b1;
        hi = 0;
        repeat (6) begin
            @(negedge clk);
            if (tready_sel) hi++;
        end
        total++;
        if (hi != 0 || ack_log.size() != 0) begin
            bad++;
            $display("FAIL busy_backpressure got ready_cycles=%0d acks=%0d want 0 0",
                     hi, ack_log.size());
        end
        rdy_a = 4'b0100;
        send_pkt(2, 8, 1'b0, 0, acc);
        repeat (4) @(negedge clk);
        total++;
        if (ack_log.size() != 1 || ack_log[0] != 2 || done_log.size() != 1 || done_log[0] != 2 ||
            a_drop !== 32'd0) begin
            bad++;
            $display("FAIL busy_late_claim got acks=%p done=%p drop=%0d want {2} {2} 0",
                     ack_log, done_log, a_drop);
        end
        rdy_a = 4'hF;
    endtask

    task automatic test_valid_toggle();
        int acc;
        int err;
        do_reset();
        send_pkt(6, 8, 1'b1, 0, acc);
        repeat (4) @(negedge clk);
        total++;
        if (wr_addr.size() != 6) begin
            bad++;
            $display("FAIL toggle_count got %0d want 6", wr_addr.size());
        end
        err = 0;
        foreach (wr_addr[k]) if (wr_addr[k] != k || wr_data[k][31:0] != 32'(k)) err++;
        total++;
        if (err != 0) begin
            bad++;
            $display("FAIL toggle_contiguous got %0d bad entries want 0", err);
        end
    endtask

    task automatic test_mid_reset();
        int acc;
        do_reset();
        send_pkt(8, 8, 1'b0, 4, acc);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({a_wr_en, a_done, a_ack, if_a.s_tready} !== 13'd0 || a_addr !== 8'd0 ||
            a_data !== 64'd0 || a_inc !== 4'd0) begin
            bad++;
            $display("FAIL midreset_outputs got wr=%h done=%h ack=%h rdy=%b addr=%h want 0",
                     a_wr_en, a_done, a_ack, if_a.s_tready, a_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (done_log.size() != 0) begin
            bad++;
            $display("FAIL midreset_no_done got %0d pulses want 0", done_log.size());
        end
        clear_logs();
        send_pkt(1, 8, 1'b0, 0, acc);
        repeat (4) @(negedge clk);
        total++;
        if (ack_log.size() != 1 || ack_log[0] != 0) begin
            bad++;
            $display("FAIL midreset_next_claim got %p want {0}", ack_log);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_rr_sparse();
        test_truncation();
        test_drop();
        test_valid_toggle();
        test_mid_reset();
        total++;
        if (onehot_bad != 0) begin
            bad++;
            $display("FAIL onehot_outputs got %0d multi-core cycles want 0", onehot_bad);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
